// File: rtl/axi_arbiter_2x1.sv
// rtl/axi_arbiter_2x1.sv - two-master to one-master AXI arbiter (icache/dcache merge)
module axi_arbiter_2x1 #(
    parameter int              ID_W   = 4,
    parameter int              ADDR_W = 32,
    parameter int              DATA_W = 32,
    parameter logic [ID_W-1:0] S0_ID  = '0,
    parameter logic [ID_W-1:0] S1_ID  = ID_W'(1)
) (
    input  logic                clk,
    input  logic                rst,
    // icache port
    input  logic [ID_W-1:0]     s0_arid,   input  logic [ADDR_W-1:0] s0_araddr,
    input  logic [7:0]          s0_arlen,  input  logic [2:0]        s0_arsize,
    input  logic [1:0]          s0_arburst, input logic              s0_arvalid,
    output logic                s0_arready,
    output logic [ID_W-1:0]     s0_rid,    output logic [DATA_W-1:0] s0_rdata,
    output logic [1:0]          s0_rresp,  output logic              s0_rlast,
    output logic                s0_rvalid, input  logic              s0_rready,
    input  logic [ID_W-1:0]     s0_awid,   input  logic [ADDR_W-1:0] s0_awaddr,
    input  logic [7:0]          s0_awlen,  input  logic [2:0]        s0_awsize,
    input  logic [1:0]          s0_awburst, input logic              s0_awvalid,
    output logic                s0_awready,
    input  logic [DATA_W-1:0]   s0_wdata,  input  logic [DATA_W/8-1:0] s0_wstrb,
    input  logic                s0_wlast,  input  logic              s0_wvalid,
    output logic                s0_wready,
    output logic [ID_W-1:0]     s0_bid,    output logic [1:0]        s0_bresp,
    output logic                s0_bvalid, input  logic              s0_bready,
    // dcache port
    input  logic [ID_W-1:0]     s1_arid,   input  logic [ADDR_W-1:0] s1_araddr,
    input  logic [7:0]          s1_arlen,  input  logic [2:0]        s1_arsize,
    input  logic [1:0]          s1_arburst, input logic              s1_arvalid,
    output logic                s1_arready,
    output logic [ID_W-1:0]     s1_rid,    output logic [DATA_W-1:0] s1_rdata,
    output logic [1:0]          s1_rresp,  output logic              s1_rlast,
    output logic                s1_rvalid, input  logic              s1_rready,
    input  logic [ID_W-1:0]     s1_awid,   input  logic [ADDR_W-1:0] s1_awaddr,
    input  logic [7:0]          s1_awlen,  input  logic [2:0]        s1_awsize,
    input  logic [1:0]          s1_awburst, input logic              s1_awvalid,
    output logic                s1_awready,
    input  logic [DATA_W-1:0]   s1_wdata,  input  logic [DATA_W/8-1:0] s1_wstrb,
    input  logic                s1_wlast,  input  logic              s1_wvalid,
    output logic                s1_wready,
    output logic [ID_W-1:0]     s1_bid,    output logic [1:0]        s1_bresp,
    output logic                s1_bvalid, input  logic              s1_bready,
    // merged master port
    output logic [ID_W-1:0]     m_arid,    output logic [ADDR_W-1:0] m_araddr,
    output logic [7:0]          m_arlen,   output logic [2:0]        m_arsize,
    output logic [1:0]          m_arburst, output logic              m_arvalid,
    input  logic                m_arready,
    input  logic [ID_W-1:0]     m_rid,     input  logic [DATA_W-1:0] m_rdata,
    input  logic [1:0]          m_rresp,   input  logic              m_rlast,
    input  logic                m_rvalid,  output logic              m_rready,
    output logic [ID_W-1:0]     m_awid,    output logic [ADDR_W-1:0] m_awaddr,
    output logic [7:0]          m_awlen,   output logic [2:0]        m_awsize,
    output logic [1:0]          m_awburst, output logic              m_awvalid,
    input  logic                m_awready,
    output logic [DATA_W-1:0]   m_wdata,   output logic [DATA_W/8-1:0] m_wstrb,
    output logic                m_wlast,   output logic              m_wvalid,
    input  logic                m_wready,
    input  logic [ID_W-1:0]     m_bid,     input  logic [1:0]        m_bresp,
    input  logic                m_bvalid,  output logic              m_bready
);

    typedef enum logic [1:0] {R_IDLE, R_ADDR, R_DATA} r_state_t;
    typedef enum logic [1:0] {W_IDLE, W_ADDR, W_DATA, W_RESP} w_state_t;

    r_state_t        r_state, r_next;
    w_state_t        w_state, w_next;
    logic            r_gnt, r_last, r_pick;   // 1 = dcache port
    logic            w_gnt, w_last, w_pick;
    logic [ID_W-1:0] r_id, w_id;

    // Responses are routed by grant, so the returned IDs are never looked at.
    logic unused_ids;
    assign unused_ids = ^{m_rid, m_bid};

    // Round robin: with both requesting, the port not served last wins.
    assign r_pick = (s0_arvalid && s1_arvalid) ? ~r_last : s1_arvalid;
    assign w_pick = (s0_awvalid && s1_awvalid) ? ~w_last : s1_awvalid;

    // State registers, grant/ID latches and last-served pointers.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state <= R_IDLE;
            w_state <= W_IDLE;
            r_gnt   <= 1'b0;
            w_gnt   <= 1'b0;
            r_last  <= 1'b0;
            w_last  <= 1'b0;
            r_id    <= '0;
            w_id    <= '0;
        end else begin
            r_state <= r_next;
            w_state <= w_next;
            if (r_state == R_IDLE && (s0_arvalid || s1_arvalid)) begin
                r_gnt <= r_pick;
                r_id  <= r_pick ? s1_arid : s0_arid;
            end
            if (r_state == R_DATA && m_rvalid && m_rready && m_rlast)
                r_last <= r_gnt;
            if (w_state == W_IDLE && (s0_awvalid || s1_awvalid)) begin
                w_gnt <= w_pick;
                w_id  <= w_pick ? s1_awid : s0_awid;
            end
            if (w_state == W_RESP && m_bvalid && m_bready)
                w_last <= w_gnt;
        end
    end

    // Next-state logic for both channel groups.
    always_comb begin
        r_next = r_state;
        case (r_state)
            R_IDLE:  if (s0_arvalid || s1_arvalid) r_next = R_ADDR;
            R_ADDR:  if (m_arvalid && m_arready) r_next = R_DATA;
            R_DATA:  if (m_rvalid && m_rready && m_rlast) r_next = R_IDLE;
            default: r_next = R_IDLE;
        endcase
        w_next = w_state;
        case (w_state)
            W_IDLE:  if (s0_awvalid || s1_awvalid) w_next = W_ADDR;
            W_ADDR:  if (m_awvalid && m_awready) w_next = W_DATA;
            W_DATA:  if (m_wvalid && m_wready && m_wlast) w_next = W_RESP;
            W_RESP:  if (m_bvalid && m_bready) w_next = W_IDLE;
            default: w_next = W_IDLE;
        endcase
    end

    // Read-side outputs: payload muxed by grant, handshakes gated by state.
    always_comb begin
        m_arid     = r_gnt ? S1_ID      : S0_ID;
        m_araddr   = r_gnt ? s1_araddr  : s0_araddr;
        m_arlen    = r_gnt ? s1_arlen   : s0_arlen;
        m_arsize   = r_gnt ? s1_arsize  : s0_arsize;
        m_arburst  = r_gnt ? s1_arburst : s0_arburst;
        m_arvalid  = (r_state == R_ADDR) && (r_gnt ? s1_arvalid : s0_arvalid);
        s0_arready = (r_state == R_ADDR) && !r_gnt && m_arready;
        s1_arready = (r_state == R_ADDR) &&  r_gnt && m_arready;
        s0_rid     = r_id;
        s0_rdata   = m_rdata;
        s0_rresp   = m_rresp;
        s0_rlast   = m_rlast;
        s1_rid     = r_id;
        s1_rdata   = m_rdata;
        s1_rresp   = m_rresp;
        s1_rlast   = m_rlast;
        s0_rvalid  = (r_state == R_DATA) && !r_gnt && m_rvalid;
        s1_rvalid  = (r_state == R_DATA) &&  r_gnt && m_rvalid;
        m_rready   = (r_state == R_DATA) && (r_gnt ? s1_rready : s0_rready);
    end

    // Write-side outputs: W stays blocked until the AW handshake is done.
    always_comb begin
        m_awid     = w_gnt ? S1_ID      : S0_ID;
        m_awaddr   = w_gnt ? s1_awaddr  : s0_awaddr;
        m_awlen    = w_gnt ? s1_awlen   : s0_awlen;
        m_awsize   = w_gnt ? s1_awsize  : s0_awsize;
        m_awburst  = w_gnt ? s1_awburst : s0_awburst;
        m_awvalid  = (w_state == W_ADDR) && (w_gnt ? s1_awvalid : s0_awvalid);
        s0_awready = (w_state == W_ADDR) && !w_gnt && m_awready;
        s1_awready = (w_state == W_ADDR) &&  w_gnt && m_awready;
        m_wdata    = w_gnt ? s1_wdata : s0_wdata;
        m_wstrb    = w_gnt ? s1_wstrb : s0_wstrb;
        m_wlast    = w_gnt ? s1_wlast : s0_wlast;
        m_wvalid   = (w_state == W_DATA) && (w_gnt ? s1_wvalid : s0_wvalid);
        s0_wready  = (w_state == W_DATA) && !w_gnt && m_wready;
        s1_wready  = (w_state == W_DATA) &&  w_gnt && m_wready;
        s0_bid     = w_id;
        s0_bresp   = m_bresp;
        s1_bid     = w_id;
        s1_bresp   = m_bresp;
        s0_bvalid  = (w_state == W_RESP) && !w_gnt && m_bvalid;
        s1_bvalid  = (w_state == W_RESP) &&  w_gnt && m_bvalid;
        m_bready   = (w_state == W_RESP) && (w_gnt ? s1_bready : s0_bready);
    end

endmodule

// File: tb/tb_axi_arbiter_2x1.sv
// tb/tb_axi_arbiter_2x1.sv - directed vector bench for axi_arbiter_2x1
module tb_axi_arbiter_2x1;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  s0_arid, s1_arid, s0_rid, s1_rid, s0_awid, s1_awid, s0_bid, s1_bid;
    logic [31:0] s0_araddr, s1_araddr, s0_awaddr, s1_awaddr;
    logic [7:0]  s0_arlen, s1_arlen, s0_awlen, s1_awlen;
    logic [2:0]  s0_arsize, s1_arsize, s0_awsize, s1_awsize;
    logic [1:0]  s0_arburst, s1_arburst, s0_awburst, s1_awburst;
    logic        s0_arvalid, s1_arvalid, s0_arready, s1_arready;
    logic [31:0] s0_rdata, s1_rdata, s0_wdata, s1_wdata;
    logic [1:0]  s0_rresp, s1_rresp, s0_bresp, s1_bresp;
    logic        s0_rlast, s1_rlast, s0_rvalid, s1_rvalid, s0_rready, s1_rready;
    logic        s0_awvalid, s1_awvalid, s0_awready, s1_awready;
    logic [3:0]  s0_wstrb, s1_wstrb;
    logic        s0_wlast, s1_wlast, s0_wvalid, s1_wvalid, s0_wready, s1_wready;
    logic        s0_bvalid, s1_bvalid, s0_bready, s1_bready;
    logic [3:0]  m_arid, m_rid, m_awid, m_bid;
    logic [31:0] m_araddr, m_awaddr, m_rdata, m_wdata;
    logic [7:0]  m_arlen, m_awlen;
    logic [2:0]  m_arsize, m_awsize;
    logic [1:0]  m_arburst, m_awburst, m_rresp, m_bresp;
    logic        m_arvalid, m_arready, m_rlast, m_rvalid, m_rready;
    logic        m_awvalid, m_awready;
    logic [3:0]  m_wstrb;
    logic        m_wlast, m_wvalid, m_wready, m_bvalid, m_bready;

    axi_arbiter_2x1 dut (
        .clk(clk), .rst(rst),
        .s0_arid(s0_arid), .s0_araddr(s0_araddr), .s0_arlen(s0_arlen), .s0_arsize(s0_arsize),
        .s0_arburst(s0_arburst), .s0_arvalid(s0_arvalid), .s0_arready(s0_arready),
        .s0_rid(s0_rid), .s0_rdata(s0_rdata), .s0_rresp(s0_rresp), .s0_rlast(s0_rlast),
        .s0_rvalid(s0_rvalid), .s0_rready(s0_rready),
        .s0_awid(s0_awid), .s0_awaddr(s0_awaddr), .s0_awlen(s0_awlen), .s0_awsize(s0_awsize),
        .s0_awburst(s0_awburst), .s0_awvalid(s0_awvalid), .s0_awready(s0_awready),
        .s0_wdata(s0_wdata), .s0_wstrb(s0_wstrb), .s0_wlast(s0_wlast), .s0_wvalid(s0_wvalid),
        .s0_wready(s0_wready), .s0_bid(s0_bid), .s0_bresp(s0_bresp), .s0_bvalid(s0_bvalid),
        .s0_bready(s0_bready),
        .s1_arid(s1_arid), .s1_araddr(s1_araddr), .s1_arlen(s1_arlen), .s1_arsize(s1_arsize),
        .s1_arburst(s1_arburst), .s1_arvalid(s1_arvalid), .s1_arready(s1_arready),
        .s1_rid(s1_rid), .s1_rdata(s1_rdata), .s1_rresp(s1_rresp), .s1_rlast(s1_rlast),
        .s1_rvalid(s1_rvalid), .s1_rready(s1_rready),
        .s1_awid(s1_awid), .s1_awaddr(s1_awaddr), .s1_awlen(s1_awlen), .s1_awsize(s1_awsize),
        .s1_awburst(s1_awburst), .s1_awvalid(s1_awvalid), .s1_awready(s1_awready),
        .s1_wdata(s1_wdata), .s1_wstrb(s1_wstrb), .s1_wlast(s1_wlast), .s1_wvalid(s1_wvalid),
        .s1_wready(s1_wready), .s1_bid(s1_bid), .s1_bresp(s1_bresp), .s1_bvalid(s1_bvalid),
        .s1_bready(s1_bready),
        .m_arid(m_arid), .m_araddr(m_araddr), .m_arlen(m_arlen), .m_arsize(m_arsize),
        .m_arburst(m_arburst), .m_arvalid(m_arvalid), .m_arready(m_arready),
        .m_rid(m_rid), .m_rdata(m_rdata), .m_rresp(m_rresp), .m_rlast(m_rlast),
        .m_rvalid(m_rvalid), .m_rready(m_rready),
        .m_awid(m_awid), .m_awaddr(m_awaddr), .m_awlen(m_awlen), .m_awsize(m_awsize),
        .m_awburst(m_awburst), .m_awvalid(m_awvalid), .m_awready(m_awready),
        .m_wdata(m_wdata), .m_wstrb(m_wstrb), .m_wlast(m_wlast), .m_wvalid(m_wvalid),
        .m_wready(m_wready), .m_bid(m_bid), .m_bresp(m_bresp), .m_bvalid(m_bvalid),
        .m_bready(m_bready)
    );

    always #5 clk = ~clk;

    // One read-channel cycle: inputs {rst,s0_arvalid,s1_arvalid,m_arready,m_rvalid,m_rlast,
    // s0_rready,s1_rready}; expected m_arvalid, m_arid and {s0_arready,s1_arready,s0_rvalid,
    // s1_rvalid,m_rready}.
    typedef struct {
        logic [7:0] in;
        logic       mav;
        logic [3:0] mid;
        logic [4:0] ex;
    } vec_t;

    vec_t tbl[31];
    int   n_vec = 0;
    int   n_bad = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic [7:0] i, input logic v, input logic [3:0] d,
                                input logic [4:0] e);
        vec_t t;
        t.in = i; t.mav = v; t.mid = d; t.ex = e;
        return t;
    endfunction

    initial begin
        int  rbeats, ar_cyc, aw_cyc;
        bit  ar_done, aw_done, w_done, b_done, s1r_seen, s0b_seen;

        // s0 read of 4 beats with a 2-cycle rready stall, then the idle bubble
        tbl[0]  = mk(8'b0000_0000, 0, 4'h0, 5'b00000);
        tbl[1]  = mk(8'b1100_0000, 0, 4'h0, 5'b00000);
        tbl[2]  = mk(8'b1100_0000, 1, 4'h0, 5'b00000);
        tbl[3]  = mk(8'b1101_0000, 1, 4'h0, 5'b10000);
        tbl[4]  = mk(8'b1000_1010, 0, 4'h0, 5'b00101);
        tbl[5]  = mk(8'b1000_1010, 0, 4'h0, 5'b00101);
        tbl[6]  = mk(8'b1000_1000, 0, 4'h0, 5'b00100);
        tbl[7]  = mk(8'b1000_1000, 0, 4'h0, 5'b00100);
        tbl[8]  = mk(8'b1000_1010, 0, 4'h0, 5'b00101);
        tbl[9]  = mk(8'b1000_1110, 0, 4'h0, 5'b00101);
        tbl[10] = mk(8'b1000_1010, 0, 4'h0, 5'b00000);
        // reset, then simultaneous requests: s1, s0, s1
        tbl[11] = mk(8'b0000_0000, 0, 4'h0, 5'b00000);
        tbl[12] = mk(8'b1110_0000, 0, 4'h0, 5'b00000);
        tbl[13] = mk(8'b1111_0000, 1, 4'h1, 5'b01000);
        tbl[14] = mk(8'b1100_1101, 0, 4'h0, 5'b00011);
        tbl[15] = mk(8'b1110_0000, 0, 4'h0, 5'b00000);
        tbl[16] = mk(8'b1111_0000, 1, 4'h0, 5'b10000);
        tbl[17] = mk(8'b1010_1110, 0, 4'h0, 5'b00101);
        tbl[18] = mk(8'b1110_0000, 0, 4'h0, 5'b00000);
        tbl[19] = mk(8'b1111_0000, 1, 4'h1, 5'b01000);
        tbl[20] = mk(8'b1100_1101, 0, 4'h0, 5'b00011);
        // reset during the second beat of an s0 burst, then a clean s1 read
        tbl[21] = mk(8'b0000_0000, 0, 4'h0, 5'b00000);
        tbl[22] = mk(8'b1100_0000, 0, 4'h0, 5'b00000);
        tbl[23] = mk(8'b1101_0000, 1, 4'h0, 5'b10000);
        tbl[24] = mk(8'b1000_1010, 0, 4'h0, 5'b00101);
        tbl[25] = mk(8'b0000_1010, 0, 4'h0, 5'b00101);
        tbl[26] = mk(8'b1000_1010, 0, 4'h0, 5'b00000);
        tbl[27] = mk(8'b1010_0000, 0, 4'h0, 5'b00000);
        tbl[28] = mk(8'b1011_0000, 1, 4'h1, 5'b01000);
        tbl[29] = mk(8'b1000_1101, 0, 4'h0, 5'b00011);
        tbl[30] = mk(8'b1000_0000, 0, 4'h0, 5'b00000);

        rst = 1'b0;
        s0_arid = 4'h5; s1_arid = 4'h9; s0_araddr = 32'h1000; s1_araddr = 32'h2000;
        s0_arlen = 8'd3; s1_arlen = 8'd0; s0_arsize = 3'd2; s1_arsize = 3'd2;
        s0_arburst = 2'b01; s1_arburst = 2'b01; s0_arvalid = 0; s1_arvalid = 0;
        s0_rready = 0; s1_rready = 0;
        s0_awid = 4'h3; s1_awid = 4'hA; s0_awaddr = 32'h3000; s1_awaddr = 32'h4000;
        s0_awlen = 8'd0; s1_awlen = 8'd1; s0_awsize = 3'd2; s1_awsize = 3'd2;
        s0_awburst = 2'b01; s1_awburst = 2'b01; s0_awvalid = 0; s1_awvalid = 0;
        s0_wdata = 0; s1_wdata = 0; s0_wstrb = 4'hF; s1_wstrb = 4'h3;
        s0_wlast = 0; s1_wlast = 0; s0_wvalid = 0; s1_wvalid = 0;
        s0_bready = 0; s1_bready = 0;
        m_arready = 0; m_rid = 4'hE; m_rdata = 0; m_rresp = 0; m_rlast = 0; m_rvalid = 0;
        m_awready = 0; m_wready = 0; m_bid = 4'h7; m_bresp = 0; m_bvalid = 0;
        repeat (2) @(posedge clk);

        for (int i = 0; i < 31; i++) begin
            @(negedge clk);
            {rst, s0_arvalid, s1_arvalid, m_arready, m_rvalid, m_rlast, s0_rready, s1_rready} = tbl[i].in;
            m_rdata = 32'hD000 + i;
            #2;
            chk($sformatf("v%0d m_arvalid", i), m_arvalid, tbl[i].mav);
            if (tbl[i].mav) chk($sformatf("v%0d m_arid", i), m_arid, tbl[i].mid);
            chk($sformatf("v%0d rd_hs", i),
                {s0_arready, s1_arready, s0_rvalid, s1_rvalid, m_rready}, tbl[i].ex);
            if (tbl[i].ex[2]) chk($sformatf("v%0d s0_rid", i), s0_rid, 4'h5);
            if (tbl[i].ex[1]) chk($sformatf("v%0d s1_rid", i), s1_rid, 4'h9);
            if (tbl[i].ex[2]) chk($sformatf("v%0d s0_rdata", i), s0_rdata, 32'hD000 + i);
        end

        // s1 write, awlen=1, AW accepted only after 3 cycles of waiting
        @(negedge clk);
        {s0_arvalid, s1_arvalid, m_arready, m_rvalid, m_rlast, s0_rready, s1_rready} = '0;
        s1_awvalid = 1; s1_wvalid = 1; s1_wdata = 32'h1111; s1_wlast = 0;
        m_wready = 1; m_awready = 0;
        #2;
        chk("w idle m_awvalid", m_awvalid, 1'b0);
        chk("w idle s1_wready", s1_wready, 1'b0);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk); #2;
            chk($sformatf("w wait%0d m_awvalid", k), m_awvalid, 1'b1);
            chk($sformatf("w wait%0d m_awid", k), m_awid, 4'h1);
            chk($sformatf("w wait%0d m_awlen", k), m_awlen, 8'd1);
            chk($sformatf("w wait%0d s1_wready", k), s1_wready, 1'b0);
            chk($sformatf("w wait%0d m_wvalid", k), m_wvalid, 1'b0);
        end
        @(negedge clk);
        m_awready = 1;
        #2;
        chk("w hs s1_awready", s1_awready, 1'b1);
        chk("w hs s1_wready", s1_wready, 1'b0);
        @(negedge clk);
        s1_awvalid = 0; m_awready = 0;
        #2;
        chk("w beat0 m_wvalid", m_wvalid, 1'b1);
        chk("w beat0 s1_wready", s1_wready, 1'b1);
        chk("w beat0 m_wdata", m_wdata, 32'h1111);
        chk("w beat0 m_wlast", m_wlast, 1'b0);
        chk("w beat0 m_wstrb", m_wstrb, 4'h3);
        @(negedge clk);
        s1_wdata = 32'h2222; s1_wlast = 1;
        #2;
        chk("w beat1 m_wdata", m_wdata, 32'h2222);
        chk("w beat1 m_wlast", m_wlast, 1'b1);
        chk("w beat1 s1_wready", s1_wready, 1'b1);
        @(negedge clk);
        s1_wvalid = 0; s1_wlast = 0; m_bvalid = 1; m_bresp = 2'b01; s1_bready = 1;
        #2;
        chk("b s1_bvalid", s1_bvalid, 1'b1);
        chk("b s1_bid", s1_bid, 4'hA);
        chk("b s1_bresp", s1_bresp, 2'b01);
        chk("b s0_bvalid", s0_bvalid, 1'b0);
        chk("b m_bready", m_bready, 1'b1);
        @(negedge clk); #2;
        chk("b done s1_bvalid", s1_bvalid, 1'b0);
        chk("b done m_bready", m_bready, 1'b0);

        // concurrent s0 read of 8 beats and s1 single write, slave always ready
        @(negedge clk);
        m_bvalid = 0; m_bresp = 0;
        s0_arlen = 8'd7; s1_awlen = 8'd0; s1_wdata = 32'h5A5A; s1_wlast = 1;
        s0_rready = 1; s1_bready = 1; m_arready = 1; m_awready = 1; m_wready = 1;
        rbeats = 0; ar_cyc = -1; aw_cyc = -1;
        ar_done = 0; aw_done = 0; w_done = 0; b_done = 0; s1r_seen = 0; s0b_seen = 0;
        for (int c = 0; c < 40 && !(rbeats == 8 && b_done); c++) begin
            if (c > 0) @(negedge clk);
            s0_arvalid = !ar_done;
            s1_awvalid = !aw_done;
            s1_wvalid  = !w_done;
            m_rvalid   = ar_done && rbeats < 8;
            m_rlast    = (rbeats == 7);
            m_rdata    = 32'hA0 + rbeats;
            m_bvalid   = w_done && !b_done;
            #2;
            if (m_arvalid && ar_cyc < 0) ar_cyc = c;
            if (m_awvalid && aw_cyc < 0) aw_cyc = c;
            if (s1_rvalid) s1r_seen = 1;
            if (s0_bvalid) s0b_seen = 1;
            if (m_arvalid && m_arready) ar_done = 1;
            if (m_awvalid && m_awready) aw_done = 1;
            if (m_wvalid && m_wready && m_wlast) w_done = 1;
            if (s0_rvalid && s0_rready) begin
                chk($sformatf("cc beat%0d data", rbeats), s0_rdata, 32'hA0 + rbeats);
                rbeats++;
            end
            if (s1_bvalid && s1_bready) b_done = 1;
        end
        chk("cc ar issue cycle", ar_cyc, 1);
        chk("cc aw issue cycle", aw_cyc, 1);
        chk("cc read beats", rbeats, 8);
        chk("cc write resp", b_done, 1'b1);
        chk("cc s1_rvalid stray", s1r_seen, 1'b0);
        chk("cc s0_bvalid stray", s0b_seen, 1'b0);

        @(negedge clk);
        {s0_arvalid, s1_awvalid, s1_wvalid, m_rvalid, m_rlast, m_bvalid} = '0;
        @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
